segment_scan_controller: RTL and testbench
==========================================

SEGMENT_SCAN_CONTROLLER -- requirements
Module: segment_scan_controller

Interface
REQ-001 Parameter BLANK_CYCLES, default 16: number of clocks all anodes stay off between digits (ghost suppression); legal range 1..255.
REQ-002 CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 SCAN_IN  input  1  toggling scan-rate level from the dynamic-lighting divider; each edge requests advance to the next digit.
REQ-005 DATA_IN  input  16  four hex digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-006 DP_IN  input  4  decimal point per digit, 1 = lit; bit n belongs to digit n.
REQ-007 LOAD  input  1  one-cycle strobe that captures DATA_IN, DP_IN and LZB_IN into the pending buffer.
REQ-008 LZB_IN  input  1  leading-zero-blanking enable, captured with LOAD.
REQ-009 AN  output  4  digit anodes, active-low; bit n drives digit n.
REQ-010 SEG  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 DP  output  1  decimal point, active-low.
REQ-012 BUSY  output  1  high while the pending buffer holds uncommitted data.
REQ-013 LOAD_ACK  output  1  one-cycle pulse when pending data is committed to the display registers.
REQ-014 FRAME_DONE  output  1  one-cycle pulse when digit 3's display slot ends.

Function
REQ-015 Edge detect: SCAN_IN shall be registered once (prev). scan_edge = SCAN_IN XOR prev, same clock domain, no synchronizer.
REQ-016 FSM states: BLANK and SHOW. A 2-bit digit index idx and an 8-bit blank counter bcnt.
REQ-017 BLANK behaviour:
- AN = 4'b1111, SEG = 7'b1111111, DP = 1.
- bcnt increments each clock.
- When bcnt = BLANK_CYCLES-1, go to SHOW and clear bcnt.
REQ-018 SHOW behaviour:
- AN bit idx = 0, all other bits = 1.
- SEG and DP are driven from display register digit idx, registered, with no combinational path from inputs.
REQ-019 In SHOW, on scan_edge, go to BLANK and set idx = idx+1 mod 4 (3 wraps to 0).
REQ-020 scan_edge while in BLANK shall be ignored and not queued.
REQ-021 FRAME_DONE shall pulse in the cycle the SHOW->BLANK transition leaves idx = 3.
REQ-022 Commit rule:
- In the FRAME_DONE cycle, if BUSY = 1, copy pending to the display registers, pulse LOAD_ACK, and clear BUSY.
- This cycle is the only commit point, so the display never changes mid-frame.
REQ-023 LOAD behaviour:
- LOAD captures pending and sets BUSY.
- LOAD while BUSY = 1 overwrites pending (latest wins), with no extra LOAD_ACK.
REQ-024 LOAD coinciding with a commit:
- The old pending is committed and LOAD_ACK pulses.
- The new data becomes pending, and BUSY stays 1.
REQ-025 Hex decode (active-low {g..a}) shall be the full 0-F set. Examples:
- 0 = 1000000
- 1 = 1111001
- 8 = 0000000
- A = 0001000
- F = 0001110
REQ-026 Leading-zero blanking (committed LZB = 1):
- Digit n (n = 3..1) shall show SEG = 1111111 if it and every higher digit are 0.
- Digit 0 is never blanked.
- DP is unaffected by blanking.
REQ-027 At most one digit anode shall be low in any cycle. In BLANK, no anode shall be low.

Reset
REQ-028 RST = 1 shall immediately force the following, regardless of state mid-frame or mid-blank:
- state = BLANK, idx = 0, bcnt = 0, prev = 0
- AN = 1111, SEG = 1111111, DP = 1
- BUSY = 0, LOAD_ACK = 0, FRAME_DONE = 0
- display registers and pending buffer all 0, LZB = 0
REQ-029 After RST deasserts, the block shall spend BLANK_CYCLES clocks in BLANK, then show digit 0 (value 0 -> SEG = 1000000).

Verification
REQ-030 Reset release with BLANK_CYCLES = 4, SCAN_IN held 0 -> AN = 1111 for 4 clocks, then AN = 1110 and SEG = 1000000 held indefinitely.
REQ-031 LOAD with DATA_IN = 16'h1A8F, DP_IN = 0100, then 4 SCAN_IN edges -> after the next FRAME_DONE, LOAD_ACK pulses once and BUSY falls. The next frame then shows:
- digit 0: SEG = 0001110 (F)
- digit 1: SEG = 0000000 (8)
- digit 2: SEG = 0001000 (A) with DP = 0
- digit 3: SEG = 1111001 (1)
Each digit slot is preceded by exactly BLANK_CYCLES clocks of AN = 1111.
REQ-032 LZB_IN = 1, DATA_IN = 16'h0005 -> digits 3..1 show SEG = 1111111 and digit 0 shows 5. With DATA_IN = 16'h0000, digit 0 shows 0.
REQ-033 Two LOADs (16'h1111 then 16'h2222) within one frame, with a third LOAD (16'h3333) in the FRAME_DONE cycle -> the commit shows 2222, LOAD_ACK pulses once, and BUSY stays 1. The next frame commits 3333.
REQ-034 SCAN_IN toggled during BLANK -> idx is unchanged and no digit is skipped. RST pulse while digit 2 is lit -> AN = 1111 asynchronously, and the scan restarts at digit 0 with pending cleared.

Source files
------------

// File: rtl/segment_scan_controller.sv
// -----------------------------------------------------------------------------
// segment_scan_controller
//
// Purpose: time-multiplexes four hex digits onto a common-anode seven-segment
// display. Each digit slot is preceded by a blanking gap of BLANK_CYCLES clocks
// with every anode off, which suppresses ghosting. Digits advance on each edge
// of SCAN_IN. New display data is double-buffered and committed only at the end
// of digit 3's slot, so a frame never mixes old and new data.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST        in   asynchronous, active-high reset
//   SCAN_IN    in   toggling scan-rate level; each edge requests the next digit
//   DATA_IN    in   [15:0] four hex digits, [3:0] is digit 0 (rightmost)
//   DP_IN      in   [3:0] decimal points, 1 = lit, bit n is digit n
//   LOAD       in   one-cycle strobe capturing DATA_IN/DP_IN/LZB_IN as pending
//   LZB_IN     in   leading-zero-blanking enable, captured with LOAD
//   AN         out  [3:0] digit anodes, active-low
//   SEG        out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   DP         out  decimal point, active-low
//   BUSY       out  pending buffer holds uncommitted data
//   LOAD_ACK   out  one-cycle pulse when pending data is committed
//   FRAME_DONE out  one-cycle pulse in the cycle digit 3's slot ends
//   DBG_STATE  out  FSM state (0 = BLANK, 1 = SHOW)
//   DBG_IDX    out  [1:0] current digit index
//
// Load handshake: LOAD is a fire-and-forget strobe; it always captures into the
// pending buffer (latest wins) and sets BUSY. BUSY falls and LOAD_ACK pulses in
// the FRAME_DONE cycle that commits the pending data. A LOAD in that same cycle
// becomes the new pending data and keeps BUSY high.
// -----------------------------------------------------------------------------
module segment_scan_controller #(
  parameter int BLANK_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SCAN_IN,
  input  logic [15:0] DATA_IN,
  input  logic [3:0]  DP_IN,
  input  logic        LOAD,
  input  logic        LZB_IN,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        BUSY,
  output logic        LOAD_ACK,
  output logic        FRAME_DONE,
  output logic        DBG_STATE,
  output logic [1:0]  DBG_IDX
);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  localparam logic [7:0] LP_BLANK_LAST = 8'(BLANK_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_idx;
  logic [1:0]  w_idx_next;
  logic [7:0]  r_bcnt;
  logic [7:0]  w_bcnt_next;
  logic        r_prev;
  logic        w_scan_edge;
  logic        w_frame_done;
  logic        w_commit;

  logic [15:0] r_pend_data;
  logic [3:0]  r_pend_dp;
  logic        r_pend_lzb;
  logic        r_busy;
  logic [15:0] r_disp_data;
  logic [3:0]  r_disp_dp;
  logic        r_disp_lzb;

  logic [3:0]  r_an;
  logic [6:0]  r_seg;
  logic        r_dp;

  logic [3:0]  w_nib;
  logic [3:0]  w_lz;
  logic        w_blank_digit;
  logic [6:0]  w_seg_dec;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Plain edge detect on the divider output; it is generated in this clock
  // domain, so no synchronizer is needed.
  assign w_scan_edge = SCAN_IN ^ r_prev;

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_BLANK;
      r_idx   <= 2'd0;
      r_bcnt  <= 8'd0;
      r_prev  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_bcnt  <= w_bcnt_next;
      r_prev  <= SCAN_IN;
    end
  end

  // FSM next-state; scan edges seen during BLANK are dropped, not queued.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_bcnt_next  = r_bcnt;
    w_frame_done = 1'b0;
    case (r_state)
      ST_BLANK: begin
        if (r_bcnt == LP_BLANK_LAST) begin
          w_state_next = ST_SHOW;
          w_bcnt_next  = 8'd0;
        end else begin
          w_bcnt_next = r_bcnt + 8'd1;
        end
      end
      ST_SHOW: begin
        if (w_scan_edge) begin
          w_state_next = ST_BLANK;
          w_idx_next   = r_idx + 2'd1;
          w_bcnt_next  = 8'd0;
          w_frame_done = (r_idx == 2'd3);
        end
      end
      default: begin
        w_state_next = ST_BLANK;
        w_bcnt_next  = 8'd0;
      end
    endcase
  end

  assign w_commit = w_frame_done & r_busy;

  // Pending buffer and display registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pend_data <= 16'd0;
      r_pend_dp   <= 4'd0;
      r_pend_lzb  <= 1'b0;
      r_busy      <= 1'b0;
      r_disp_data <= 16'd0;
      r_disp_dp   <= 4'd0;
      r_disp_lzb  <= 1'b0;
    end else begin
      // The commit reads the old pending value, so a coincident LOAD is
      // not lost: it simply becomes the next pending data.
      if (w_commit) begin
        r_disp_data <= r_pend_data;
        r_disp_dp   <= r_pend_dp;
        r_disp_lzb  <= r_pend_lzb;
      end
      if (LOAD) begin
        r_pend_data <= DATA_IN;
        r_pend_dp   <= DP_IN;
        r_pend_lzb  <= LZB_IN;
        r_busy      <= 1'b1;
      end else if (w_commit) begin
        r_busy <= 1'b0;
      end
    end
  end

  // Leading-zero flags: digit n is a leading zero if it and all higher digits
  // are zero. Digit 0 is never blanked.
  assign w_lz[3] = (r_disp_data[15:12] == 4'd0);
  assign w_lz[2] = w_lz[3] & (r_disp_data[11:8] == 4'd0);
  assign w_lz[1] = w_lz[2] & (r_disp_data[7:4] == 4'd0);
  assign w_lz[0] = 1'b0;

  // Outputs are registered from the next state so AN/SEG/DP line up with the
  // state register. The display registers only change on a SHOW->BLANK edge,
  // so reading them for the entered digit is always stable.
  assign w_nib         = r_disp_data[{w_idx_next, 2'b00} +: 4];
  assign w_blank_digit = r_disp_lzb & w_lz[w_idx_next];
  assign w_seg_dec     = hex_to_seg(w_nib);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else if (w_state_next == ST_SHOW) begin
      r_an  <= ~(4'b0001 << w_idx_next);
      r_seg <= w_blank_digit ? 7'b1111111 : w_seg_dec;
      r_dp  <= ~r_disp_dp[w_idx_next];
    end else begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end
  end

  assign AN         = r_an;
  assign SEG        = r_seg;
  assign DP         = r_dp;
  assign BUSY       = r_busy;
  assign LOAD_ACK   = w_commit;
  assign FRAME_DONE = w_frame_done;
  assign DBG_STATE  = r_state;
  assign DBG_IDX    = r_idx;

endmodule

// File: tb/tb_segment_scan_controller.sv
module tb_segment_scan_controller;

  localparam int BC = 4;

  // ---------------- clock / reset / DUT ----------------
  logic        CLK;
  logic        RST;
  logic        SCAN_IN;
  logic [15:0] DATA_IN;
  logic [3:0]  DP_IN;
  logic        LOAD;
  logic        LZB_IN;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP;
  logic        BUSY;
  logic        LOAD_ACK;
  logic        FRAME_DONE;
  logic        DBG_STATE;
  logic [1:0]  DBG_IDX;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  segment_scan_controller #(.BLANK_CYCLES(BC)) dut (
    .CLK(CLK), .RST(RST), .SCAN_IN(SCAN_IN), .DATA_IN(DATA_IN), .DP_IN(DP_IN),
    .LOAD(LOAD), .LZB_IN(LZB_IN), .AN(AN), .SEG(SEG), .DP(DP), .BUSY(BUSY),
    .LOAD_ACK(LOAD_ACK), .FRAME_DONE(FRAME_DONE), .DBG_STATE(DBG_STATE),
    .DBG_IDX(DBG_IDX)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] tb_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0]      data;
    logic [3:0]       dp;
    logic             lzb;
    logic [3:0][6:0]  seg;   // {digit3, digit2, digit1, digit0}
    logic [3:0]       dpo;   // expected active-low DP, bit n = digit n
  } vec_t;

  vec_t vecs[7];

  // ---------------- driver tasks ----------------
  // Starts at a negedge; counts negedges with all anodes off, optionally
  // toggling SCAN_IN mid-gap. Bounded so a stuck DUT cannot hang the run.
  task automatic wait_blank(input int glitch_at, output int cnt);
    cnt = 0;
    while (AN == 4'b1111 && cnt < 40) begin
      cnt++;
      if (cnt == glitch_at) SCAN_IN = ~SCAN_IN;
      @(negedge CLK);
    end
  endtask

  // Called at a negedge while a digit is shown: requests the next digit and
  // returns at the first negedge of the following SHOW slot.
  task automatic step(input logic do_load, input logic [15:0] d, input logic [3:0] dp,
                      input logic lzb, input int glitch_at,
                      output logic fd, output logic ack, output int cnt);
    SCAN_IN = ~SCAN_IN;
    if (do_load) begin
      DATA_IN = d; DP_IN = dp; LZB_IN = lzb; LOAD = 1'b1;
    end
    #1;
    fd  = FRAME_DONE;
    ack = LOAD_ACK;
    @(negedge CLK);
    LOAD = 1'b0;
    wait_blank(glitch_at, cnt);
    tb_idx = tb_idx + 2'd1;
  endtask

  task automatic step_chk(input logic exp_fd, input logic exp_ack);
    logic fd, ack;
    int   cnt;
    step(1'b0, 16'h0, 4'h0, 1'b0, -1, fd, ack, cnt);
    chk("frame_done", 32'(fd), 32'(exp_fd));
    chk("load_ack", 32'(ack), 32'(exp_ack));
    chk("blank_len", 32'(cnt), 32'(BC));
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic lzb,
                         output logic ack);
    DATA_IN = d; DP_IN = dp; LZB_IN = lzb; LOAD = 1'b1;
    #1;
    ack = LOAD_ACK;
    @(negedge CLK);
    LOAD = 1'b0;
  endtask

  task automatic check_digit(input int n, input logic [6:0] seg, input logic dpo);
    logic [3:0] an_exp;
    an_exp = 4'b1111;
    an_exp[n] = 1'b0;
    chk("an", 32'(AN), 32'(an_exp));
    chk("seg", 32'(SEG), 32'(seg));
    chk("dp", 32'(DP), 32'(dpo));
    chk("dbg_idx", 32'(DBG_IDX), 32'(n));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    logic ack, fd;
    int   cnt, bad;

    vecs[0] = '{16'h1A8F, 4'b0100, 1'b0,
                {7'b1111001, 7'b0001000, 7'b0000000, 7'b0001110}, 4'b1011};
    vecs[1] = '{16'h0005, 4'b0000, 1'b1,
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b0010010}, 4'b1111};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1,
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b1111};
    vecs[3] = '{16'h0203, 4'b1001, 1'b1,
                {7'b1111111, 7'b0100100, 7'b1000000, 7'b0110000}, 4'b0110};
    vecs[4] = '{16'hCDE9, 4'b0000, 1'b0,
                {7'b1000110, 7'b0100001, 7'b0000110, 7'b0010000}, 4'b1111};
    vecs[5] = '{16'h0B00, 4'b0010, 1'b0,
                {7'b1000000, 7'b0000011, 7'b1000000, 7'b1000000}, 4'b1101};
    vecs[6] = '{16'h0070, 4'b0000, 1'b1,
                {7'b1111111, 7'b1111111, 7'b1111000, 7'b1000000}, 4'b1111};

    RST = 1'b1; SCAN_IN = 1'b0; LOAD = 1'b0; DATA_IN = 16'h0; DP_IN = 4'h0; LZB_IN = 1'b0;
    tb_idx = 2'd0;
    repeat (3) @(negedge CLK);

    // Reset state
    chk("rst_an", 32'(AN), 32'h F);
    chk("rst_seg", 32'(SEG), 32'h7F);
    chk("rst_dp", 32'(DP), 32'h1);
    chk("rst_busy", 32'(BUSY), 32'h0);
    chk("rst_ack", 32'(LOAD_ACK), 32'h0);
    chk("rst_fd", 32'(FRAME_DONE), 32'h0);
    chk("rst_state", 32'(DBG_STATE), 32'h0);

    // Reset release: BC blank clocks, then digit 0 showing 0, held forever
    RST = 1'b0;
    wait_blank(-1, cnt);
    chk("rel_blank_len", 32'(cnt), 32'(BC));
    check_digit(0, 7'b1000000, 1'b1);
    bad = 0;
    repeat (10) begin
      @(negedge CLK);
      if (AN !== 4'b1110 || SEG !== 7'b1000000) bad++;
    end
    chk("rel_hold", 32'(bad), 32'h0);

    // Table-driven: load, commit at the frame end, then walk the next frame
    for (int i = 0; i < 7; i++) begin
      do_load(vecs[i].data, vecs[i].dp, vecs[i].lzb, ack);
      chk("load_no_ack", 32'(ack), 32'h0);
      chk("busy_set", 32'(BUSY), 32'h1);
      while (tb_idx != 2'd3) step_chk(1'b0, 1'b0);
      step_chk(1'b1, 1'b1);
      chk("busy_clr", 32'(BUSY), 32'h0);
      for (int n = 0; n < 4; n++) begin
        check_digit(n, vecs[i].seg[n], vecs[i].dpo[n]);
        if (n < 3) step_chk(1'b0, 1'b0);
      end
      step_chk(1'b1, 1'b0);
    end

    // Latest-wins loads and a LOAD coinciding with the commit
    do_load(16'h1111, 4'h0, 1'b0, ack);
    step_chk(1'b0, 1'b0);
    do_load(16'h2222, 4'h0, 1'b0, ack);
    chk("reload_no_ack", 32'(ack), 32'h0);
    step_chk(1'b0, 1'b0);
    step_chk(1'b0, 1'b0);
    step(1'b1, 16'h3333, 4'h0, 1'b0, -1, fd, ack, cnt);
    chk("coinc_fd", 32'(fd), 32'h1);
    chk("coinc_ack", 32'(ack), 32'h1);
    chk("coinc_blank_len", 32'(cnt), 32'(BC));
    chk("coinc_busy", 32'(BUSY), 32'h1);
    check_digit(0, 7'b0100100, 1'b1);
    step_chk(1'b0, 1'b0);
    step_chk(1'b0, 1'b0);
    step_chk(1'b0, 1'b0);
    step_chk(1'b1, 1'b1);
    chk("coinc_busy_clr", 32'(BUSY), 32'h0);
    check_digit(0, 7'b0110000, 1'b1);

    // SCAN_IN edge during BLANK is dropped: digit 1 appears and stays
    step(1'b0, 16'h0, 4'h0, 1'b0, 2, fd, ack, cnt);
    chk("glitch_blank_len", 32'(cnt), 32'(BC));
    check_digit(1, 7'b0110000, 1'b1);
    bad = 0;
    repeat (6) begin
      @(negedge CLK);
      if (AN !== 4'b1101) bad++;
    end
    chk("glitch_hold", 32'(bad), 32'h0);

    // Asynchronous reset while digit 2 is lit, with data pending
    step_chk(1'b0, 1'b0);
    check_digit(2, 7'b0110000, 1'b1);
    do_load(16'hFFFF, 4'hF, 1'b0, ack);
    chk("pre_rst_busy", 32'(BUSY), 32'h1);
    #2 RST = 1'b1;
    #1;
    chk("async_an", 32'(AN), 32'hF);
    chk("async_seg", 32'(SEG), 32'h7F);
    chk("async_dp", 32'(DP), 32'h1);
    chk("async_busy", 32'(BUSY), 32'h0);
    chk("async_idx", 32'(DBG_IDX), 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    tb_idx = 2'd0;
    wait_blank(-1, cnt);
    chk("rst2_blank_len", 32'(cnt), 32'(BC));
    check_digit(0, 7'b1000000, 1'b1);
    chk("rst2_busy", 32'(BUSY), 32'h0);
    step_chk(1'b0, 1'b0);
    check_digit(1, 7'b1000000, 1'b1);
    step_chk(1'b0, 1'b0);
    step_chk(1'b0, 1'b0);
    step_chk(1'b1, 1'b0);
    check_digit(0, 7'b1000000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
